mc_control: RTL

Multicycle control unit for the 32-bit word-addressed CPU datapath. It decodes the latched instruction's opcode and funct fields and the ALU zero flag. Each cycle it drives every datapath select/enable plus ALU, memory and register-file strobes. It also owns a request/acknowledge handshake that parks the core so an external agent can use the datapath's memory override path.

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_alu_dec.sv | 24 ++
 rtl/mc_control.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: opcodes, functs, ALU and
// operand-select encodings, and FSM state codes (ADDI states need MC_CTRL_ADDI_EN).
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUB_REGB = 2'b00;
    localparam logic [1:0] ALUB_ONE  = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_ZERO = 2'b11;

    localparam logic [3:0] S_HOLD    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_RTYPEEX = 4'd7;
    localparam logic [3:0] S_RTYPEWB = 4'd8;
    localparam logic [3:0] S_BEQEX   = 4'd9;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
`endif

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported
// functs (those fall back to add so the ALU inputs stay well defined).
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        alu_ctrl    = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control FSM with an ext_req/ext_ack park handshake honoured
// only at instruction retire. Define MC_CTRL_ADDI_EN to support ADDI.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ext_req,
    output logic       ext_ack,
    output logic       MemtoRegSel,
    output logic       ALUASrcSel,
    output logic       RegDstSel,
    output logic       PCSrcSel,
    output logic       IorDSel,
    output logic       IRWriteEn,
    output logic       PCEn,
    output logic [1:0] ALUBSrcSel,
    output logic [2:0] alu_ctrl,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [3:0] retire_state;
    logic       pc_write;
    logic       branch;
    logic [2:0] rtype_alu;
    logic       funct_valid;

    mc_alu_dec u_alu_dec (
        .funct       (funct),
        .alu_ctrl    (rtype_alu),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_HOLD;
        else
            state_reg <= state_next;
    end

    // Park requests are only sampled when an instruction completes.
    assign retire_state = ext_req ? S_HOLD : S_FETCH;
    assign PCEn         = pc_write | (branch & zero);

    always_comb begin
        state_next  = S_HOLD;
        ext_ack     = 1'b0;
        MemtoRegSel = 1'b0;
        ALUASrcSel  = 1'b0;
        RegDstSel   = 1'b0;
        PCSrcSel    = 1'b0;
        IorDSel     = 1'b0;
        IRWriteEn   = 1'b0;
        ALUBSrcSel  = ALUB_REGB;
        alu_ctrl    = ALU_ADD;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        case (state_reg)
            S_HOLD: begin
                ext_ack    = 1'b1;
                state_next = ext_req ? S_HOLD : S_FETCH;
            end
            S_FETCH: begin
                mem_read   = 1'b1;
                IRWriteEn  = 1'b1;
                ALUBSrcSel = ALUB_ONE;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUBSrcSel = ALUB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_next = S_ADDIEX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        state_next = retire_state;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUASrcSel = 1'b1;
                ALUBSrcSel = ALUB_IMM;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorDSel    = 1'b1;
                mem_read   = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoRegSel = 1'b1;
                reg_write   = 1'b1;
                state_next  = retire_state;
            end
            S_MEMWR: begin
                IorDSel    = 1'b1;
                mem_write  = 1'b1;
                state_next = retire_state;
            end
            S_RTYPEEX: begin
                ALUASrcSel = 1'b1;
                alu_ctrl   = rtype_alu;
                if (funct_valid) begin
                    state_next = S_RTYPEWB;
                end else begin
                    illegal    = 1'b1;
                    state_next = retire_state;
                end
            end
            S_RTYPEWB: begin
                RegDstSel  = 1'b1;
                reg_write  = 1'b1;
                state_next = retire_state;
            end
            S_BEQEX: begin
                ALUASrcSel = 1'b1;
                alu_ctrl   = ALU_SUB;
                PCSrcSel   = 1'b1;
                branch     = 1'b1;
                state_next = retire_state;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUASrcSel = 1'b1;
                ALUBSrcSel = ALUB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                state_next = retire_state;
            end
`endif
            default: state_next = S_HOLD;
        endcase
    end

endmodule
